// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_parser
//  Description : Byte-level command parser between the UART receiver and
//                out_trigger.
//
//                The parser collects received bytes into 4-byte frames:
//                SYNC, CMD, ARG and CHK, where CHK = CMD ^ ARG. It checks
//                each frame and then does one of the following:
//                  - CMD 01: trigger. Loads ARG[1:0] into pulse_rate and
//                    pulses new_pattern.
//                  - CMD 02: rate only. Loads ARG[1:0] into pulse_rate.
//                Any other frame is rejected. A frame that stalls longer
//                than TIMEOUT_CYCLES between bytes is also rejected.
//                A rejected frame pulses frame_err and increments the
//                saturating err_count.
//
//  Parameters  : TIMEOUT_CYCLES - inter-byte gap limit, in clock cycles
//                SYNC_BYTE      - frame start marker
//
//  Ports       : clock        in   system clock
//                n_reset      in   asynchronous active-low reset
//                rx_data[7:0] in   received byte, qualified by rx_valid
//                rx_valid     in   one-cycle strobe per received byte
//                new_pattern  out  one-cycle pulse per accepted trigger
//                pulse_rate   out  registered rate select, held
//                frame_err    out  one-cycle pulse per rejected frame
//                err_count    out  saturating rejected-frame count
//
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_parser #(
  parameter int         TIMEOUT_CYCLES = 270000,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
  input  logic       clock,
  input  logic       n_reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       new_pattern,
  output logic [1:0] pulse_rate,
  output logic       frame_err,
  output logic [7:0] err_count
);

  localparam int GAP_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] CMD_TRIGGER = 8'h01;
  localparam logic [7:0] CMD_RATE    = 8'h02;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    GET_CMD = 2'd1,
    GET_ARG = 2'd2,
    GET_CHK = 2'd3
  } state_t;

  state_t           r_state;
  logic [7:0]       r_cmd;
  logic [7:0]       r_arg;
  logic [GAP_W-1:0] r_gap;

  state_t           w_state_next;
  logic [7:0]       w_cmd_next;
  logic [7:0]       w_arg_next;
  logic [GAP_W-1:0] w_gap_next;
  logic             w_new_pattern_next;
  logic             w_frame_err_next;
  logic [1:0]       w_pulse_rate_next;
  logic [7:0]       w_err_count_next;
  logic             w_frame_ok;

  // The frame check is evaluated against the byte currently on rx_data.
  // It is only used in GET_CHK, where that byte is the checksum.
  assign w_frame_ok = ((r_cmd == CMD_TRIGGER) || (r_cmd == CMD_RATE)) &&
                      (r_arg[7:2] == 6'd0) &&
                      (rx_data == (r_cmd ^ r_arg));

  always_comb begin
    w_state_next       = r_state;
    w_cmd_next         = r_cmd;
    w_arg_next         = r_arg;
    w_gap_next         = r_gap;
    w_new_pattern_next = 1'b0;
    w_frame_err_next   = 1'b0;
    w_pulse_rate_next  = pulse_rate;
    w_err_count_next   = err_count;

    if (rx_valid) begin
      // A byte always takes priority over a timeout that expires in the
      // same cycle.
      w_gap_next = '0;
      case (r_state)
        HUNT: begin
          if (rx_data == SYNC_BYTE) begin
            w_state_next = GET_CMD;
          end
        end
        GET_CMD: begin
          w_cmd_next   = rx_data;
          w_state_next = GET_ARG;
        end
        GET_ARG: begin
          w_arg_next   = rx_data;
          w_state_next = GET_CHK;
        end
        GET_CHK: begin
          w_state_next = HUNT;
          if (w_frame_ok) begin
            w_pulse_rate_next  = r_arg[1:0];
            w_new_pattern_next = (r_cmd == CMD_TRIGGER);
          end else begin
            w_frame_err_next = 1'b1;
          end
        end
        default: w_state_next = HUNT;
      endcase
    end else if (r_state == HUNT) begin
      w_gap_next = '0;
    end else if (r_gap == GAP_LAST) begin
      w_state_next     = HUNT;
      w_gap_next       = '0;
      w_frame_err_next = 1'b1;
    end else begin
      w_gap_next = r_gap + GAP_W'(1);
    end

    if (w_frame_err_next && (err_count != 8'hFF)) begin
      w_err_count_next = err_count + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_state     <= HUNT;
      r_cmd       <= 8'h00;
      r_arg       <= 8'h00;
      r_gap       <= '0;
      new_pattern <= 1'b0;
      frame_err   <= 1'b0;
      pulse_rate  <= 2'b00;
      err_count   <= 8'h00;
    end else begin
      r_state     <= w_state_next;
      r_cmd       <= w_cmd_next;
      r_arg       <= w_arg_next;
      r_gap       <= w_gap_next;
      new_pattern <= w_new_pattern_next;
      frame_err   <= w_frame_err_next;
      pulse_rate  <= w_pulse_rate_next;
      err_count   <= w_err_count_next;
    end
  end

endmodule
`default_nettype wire

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Byte-level command parser between the UART receiver and `out_trigger`. Consumes received bytes, frames them into 4-byte commands (sync, command, argument, checksum), validates each frame, and drives `new_pattern` / `pulse_rate` into the trigger stage. Malformed or stalled frames are discarded and counted.

## Interface

- `TIMEOUT_CYCLES`, default 270000: inter-byte gap limit in clock cycles (10 ms at 27 MHz).
- `SYNC_BYTE`, default 8'hA5: frame start marker.

- `clock` input 1: system clock, 27 MHz.
- `n_reset` input 1: asynchronous, active-low reset.
- `rx_data` input 8: received byte; valid only while `rx_valid`=1.
- `rx_valid` input 1: one-cycle strobe per received byte.
- `new_pattern` output 1: one-cycle pulse on each accepted trigger frame; connects to `out_trigger.new_pattern_in`.
- `pulse_rate` output 2: registered rate selection, held between frames.
- `frame_err` output 1: one-cycle pulse on each rejected or timed-out frame.
- `err_count` output 8: saturating count of rejected frames.

## Operation

- Frame format: `SYNC_BYTE`, `CMD`, `ARG`, `CHK`.
  - `CHK` = `CMD` XOR `ARG`.
  - `CMD` 8'h01: trigger. Load `ARG[1:0]` into `pulse_rate` and pulse `new_pattern`.
  - `CMD` 8'h02: set rate only. Load `ARG[1:0]` into `pulse_rate`; no `new_pattern`.
  - Any other `CMD`, or `ARG[7:2]` != 0, or a checksum mismatch, rejects the frame.
- State machine (2-bit encoding). `CMD` and `ARG` are held in internal registers.
  - HUNT: on `rx_valid` with `rx_data`==`SYNC_BYTE`, go to GET_CMD. Other bytes are dropped silently: no `frame_err`, no count.
  - GET_CMD: on `rx_valid`, latch `CMD` and go to GET_ARG.
  - GET_ARG: on `rx_valid`, latch `ARG` and go to GET_CHK.
  - GET_CHK: on `rx_valid`, validate the frame and go to HUNT.
    - Valid frame: execute the command.
    - Invalid frame: pulse `frame_err`.
- No resync inside a frame. A `SYNC_BYTE` value in GET_CMD, GET_ARG or GET_CHK is treated as data.
- Timeout:
  - A gap counter clears on every `rx_valid`, and while in HUNT.
  - In any other state it increments each cycle.
  - When it reaches `TIMEOUT_CYCLES`-1 with no `rx_valid` that cycle: go to HUNT, pulse `frame_err`, and increment `err_count`.
- `err_count`: +1 per `frame_err` pulse; saturates at 8'hFF with no wrap.
- `pulse_rate` changes only on an accepted frame. Rejected frames leave it unchanged.

## Timing

- Reset values (async assert; release synchronous to `clock`):
  - state HUNT, gap counter 0
  - `new_pattern` 0, `frame_err` 0
  - `pulse_rate` 2'b00, `err_count` 8'h00
- Latency: all outputs are registered.
  - `new_pattern`, `frame_err` and the `pulse_rate` update take effect on the clock edge after the cycle in which the `CHK` byte is strobed.
  - `pulse_rate` is valid on the same edge `new_pattern` rises, and holds, so `out_trigger` sees a stable value when it samples one cycle later.
- Back-to-back operation: the cycle after `CHK` is accepted, the parser is in HUNT. A `SYNC_BYTE` strobed on that cycle starts a new frame with no dead cycles.
- Simultaneous `rx_valid` and timeout expiry: the byte wins. It is processed normally, the counter clears, and no timeout is taken.
- `rx_valid` is never asserted on consecutive cycles by the UART receiver. The parser still accepts one byte per cycle if it is.
- Reset mid-frame: the partial frame is lost, with no `frame_err`, and all outputs return to their reset values.
- Gap counter width: 19 bits minimum for the default `TIMEOUT_CYCLES`; sized from the parameter via $clog2.

## Test plan

- Valid trigger, bytes A5 01 03 02 spaced 2344 cycles apart.
  - Required: `new_pattern`=1 for exactly 1 cycle, on the edge after the 02 strobe; `pulse_rate`=2'b11 from that edge on.
  - Required: `frame_err` stays 0 and `err_count` stays 0.
- Rate-only frame A5 02 01 03, then trigger frame A5 01 01 00.
  - Required: `pulse_rate`=01 after the first frame with no `new_pattern`.
  - Required: the second frame gives one `new_pattern` pulse with `pulse_rate` still 01.
- Errors:
  - Bad checksum A5 01 02 00: one `frame_err` pulse, `err_count`=1, `pulse_rate` unchanged.
  - Bad `CMD` A5 07 00 07: `err_count`=2.
  - Bad `ARG` A5 01 04 05: `err_count`=3.
  - Noise bytes 00 FF 3C in HUNT: no `frame_err`.
- Timeout, with `TIMEOUT_CYCLES`=100 for this test.
  - Stimulus: A5 01, then silence.
  - Required: `frame_err` exactly 100 cycles after the 01 strobe, state back in HUNT.
  - Follow-up: a complete valid frame afterwards is accepted.
  - Second run: strobe `ARG` on exactly the expiry cycle. Required: no timeout, and the frame completes.
- Saturation and reset.
  - Stimulus: 260 bad-checksum frames. Required: `err_count` stops at FF.
  - Stimulus: assert `n_reset` low after A5 01 of a valid frame. Required: all outputs at reset values immediately.
  - Stimulus: after release, send 03 02. Required: both bytes are ignored, with no `new_pattern`.
- Back-to-back frames A5 01 00 01 A5 01 02 03 with `rx_valid` every 2 cycles.
  - Required: two `new_pattern` pulses, 8 cycles apart.
  - Required: `pulse_rate` reads 00 then 10.
